uart_tx_periph: RTL and testbench

Memory-mapped UART transmitter on the data side of the RV32IM memory interconnect, beside the GPIO block. The core's memory stage writes bytes into an internal FIFO through a 4-word register window. A bit-timing state machine serialises them as 8N1 frames on a single `tx` pin. Read data is combinational so it lands in the MEM/WB register in the same cycle as the access.

---
 rtl/uart_pkg.sv | 33 +++
 rtl/uart_tx_fifo.sv | 61 ++++++
 rtl/uart_tx_periph.sv | 198 +++++++++++++++++++
 tb/tb_uart_tx_periph.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
// Contents:
//   - register byte offsets inside the 4-word window
//   - STATUS bit positions
//   - transmit FSM state type
//   - wordOff(): reduces a byte offset to its word-aligned register offset
package uart_pkg;

  localparam logic [3:0] OFF_TXDATA  = 4'h0;
  localparam logic [3:0] OFF_STATUS  = 4'h4;
  localparam logic [3:0] OFF_DIVISOR = 4'h8;
  localparam logic [3:0] OFF_CTRL    = 4'hC;

  localparam int ST_BUSY    = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_EMPTY   = 2;
  localparam int ST_OVF     = 3;
  localparam int ST_CNT_LSB = 4;
  localparam int ST_CNT_W   = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } txState_t;

  // Byte-offset bits [1:0] are not decoded.
  function automatic logic [3:0] wordOff(input logic [3:0] a);
    return {a[3:2], 2'b00};
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART transmitter.
// Ports:
//   clk, reset    : clock, synchronous active-low reset
//   push, din     : write request and byte
//   pop, dout     : read request; dout shows the head entry combinationally
//   full, empty   : occupancy flags
//   count         : number of stored bytes (log2(DEPTH)+1 bits)
// A push while full is dropped unless a pop happens in the same cycle; in
// that case the freed slot takes the new byte and count is unchanged.
module uart_tx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;
  logic [AW:0]   cnt;
  logic          doPush;
  logic          doPop;

  assign full   = (cnt == (AW+1)'(DEPTH));
  assign empty  = (cnt == '0);
  assign count  = cnt;
  assign dout   = mem[rdPtr];
  assign doPop  = pop & ~empty;
  assign doPush = push & (~full | doPop);

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= din;
  end

  // Pointers are exactly AW bits wide so they wrap without extra logic.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      cnt   <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + AW'(1);
      if (doPop)  rdPtr <= rdPtr + AW'(1);
      case ({doPush, doPop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_periph.sv
// Memory-mapped UART transmitter (8N1) for the data-side interconnect.
// Ports:
//   clk, reset : clock, synchronous active-low reset
//   sel, we    : block select and write strobe from the memory stage
//   addr       : byte offset in the register window (bits [1:0] ignored)
//   wdata      : write data
//   rdata      : combinational read data, 0 when not selected
//   tx         : registered serial output, idles high
//   irq        : level interrupt, only when UART_TX_IRQ_EN is defined
//   dbgState   : current transmit FSM state
// Bus handshake: an access is a single cycle with no backpressure; a write
// takes effect on the rising edge where sel && we, and read data is valid in
// the same cycle that sel is high.
// Register map: 0x0 TXDATA (W), 0x4 STATUS, 0x8 DIVISOR, 0xC CTRL.
// Build option: define UART_TX_IRQ_EN for the irq output and CTRL[1].
module uart_tx_periph
  import uart_pkg::*;
#(
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic        we,
  input  logic [3:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        tx,
`ifdef UART_TX_IRQ_EN
  output logic        irq,
`endif
  output logic [1:0]  dbgState
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  txState_t    state;
  txState_t    nextState;
  logic [15:0] divisor;
  logic [15:0] bitCnt;
  logic [2:0]  bitIdx;
  logic [2:0]  nextIdx;
  logic [7:0]  shiftReg;
  logic        txNext;
  logic        txEn;
  logic        irqEn;
  logic        overflow;
  logic        busy;
  logic        bitDone;
  logic [3:0]  regOff;
  logic        wrHit;
  logic        fifoPush;
  logic        fifoPop;
  logic [7:0]  fifoDout;
  logic        fifoFull;
  logic        fifoEmpty;
  logic [CW-1:0] fifoCount;
  logic        unusedBits;

  assign regOff     = wordOff(addr);
  assign wrHit      = sel & we;
  assign fifoPush   = wrHit && (regOff == OFF_TXDATA);
  assign busy       = (state != IDLE);
  // divisor is never 0, so divisor-1 cannot underflow. The >= keeps a bit
  // finite when DIVISOR is lowered below the running count.
  assign bitDone    = (bitCnt >= divisor - 16'd1);
  assign dbgState   = state;
  assign unusedBits = ^{wdata[31:16], wdata[1], addr[1:0]};

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifoPush),
    .pop   (fifoPop),
    .din   (wdata[7:0]),
    .dout  (fifoDout),
    .full  (fifoFull),
    .empty (fifoEmpty),
    .count (fifoCount)
  );

  // Next state, pop request and next line level. tx is registered from the
  // level belonging to the next state so the pin changes with the state.
  always_comb begin
    nextState = state;
    nextIdx   = bitIdx;
    fifoPop   = 1'b0;
    case (state)
      IDLE: begin
        if (txEn && !fifoEmpty) begin
          fifoPop   = 1'b1;
          nextState = START;
        end
      end
      START: begin
        if (bitDone) begin
          nextState = DATA;
          nextIdx   = 3'd0;
        end
      end
      DATA: begin
        if (bitDone) begin
          if (bitIdx == 3'd7) nextState = STOP;
          else                nextIdx   = bitIdx + 3'd1;
        end
      end
      STOP: begin
        if (bitDone) begin
          // Chain straight into the next start bit when data is waiting.
          if (txEn && !fifoEmpty) begin
            fifoPop   = 1'b1;
            nextState = START;
          end else begin
            nextState = IDLE;
          end
        end
      end
      default: nextState = IDLE;
    endcase

    case (nextState)
      START:   txNext = 1'b0;
      DATA:    txNext = shiftReg[nextIdx];
      default: txNext = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      bitCnt   <= '0;
      bitIdx   <= '0;
      shiftReg <= '0;
      tx       <= 1'b1;
    end else begin
      state  <= nextState;
      bitIdx <= nextIdx;
      tx     <= txNext;
      if (fifoPop) shiftReg <= fifoDout;
      // Restart timing at the end of every bit (which covers every state
      // entry); IDLE holds the counter at 0.
      if (state == IDLE || bitDone) bitCnt <= '0;
      else                          bitCnt <= bitCnt + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      divisor  <= DEFAULT_DIV;
      txEn     <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (wrHit) begin
        case (regOff)
          OFF_STATUS:  if (wdata[ST_OVF]) overflow <= 1'b0;
          OFF_DIVISOR: divisor <= (wdata[15:0] == 16'd0) ? 16'd1 : wdata[15:0];
          OFF_CTRL:    txEn <= wdata[0];
          default:     ;
        endcase
      end
      if (fifoPush && fifoFull && !fifoPop) overflow <= 1'b1;
    end
  end

`ifdef UART_TX_IRQ_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      irqEn <= 1'b0;
      irq   <= 1'b0;
    end else begin
      if (wrHit && regOff == OFF_CTRL) irqEn <= wdata[1];
      irq <= irqEn & fifoEmpty & ~busy;
    end
  end
`else
  assign irqEn = 1'b0;
`endif

  always_comb begin
    rdata = '0;
    if (sel) begin
      case (regOff)
        OFF_STATUS: begin
          rdata[ST_BUSY]                   = busy;
          rdata[ST_FULL]                   = fifoFull;
          rdata[ST_EMPTY]                  = fifoEmpty;
          rdata[ST_OVF]                    = overflow;
          rdata[ST_CNT_LSB +: ST_CNT_W]    = ST_CNT_W'(fifoCount);
        end
        OFF_DIVISOR: rdata[15:0] = divisor;
        OFF_CTRL:    rdata[1:0]  = {irqEn, txEn};
        default:     rdata       = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_periph.sv
// Directed bench for uart_tx_periph: register access, frame timing,
// back-to-back frames, FIFO overflow, full push/pop, divisor/ctrl
// boundaries, optional irq (UART_TX_IRQ_EN) and reset during a frame.
module tb_uart_tx_periph;

  logic        clk;
  logic        reset;
  logic        sel;
  logic        we;
  logic [3:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        tx;
  logic        irq;
  logic [1:0]  dbgState;

  int passCnt  = 0;
  int totalCnt = 0;

  logic [7:0]  expQ[$];
  logic        txRec[$];
  logic        recOn = 1'b0;
  logic [31:0] rv;

  uart_tx_periph #(.FIFO_DEPTH(8), .DEFAULT_DIV(16'd868)) dut (
    .clk      (clk),
    .reset    (reset),
    .sel      (sel),
    .we       (we),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .tx       (tx),
`ifdef UART_TX_IRQ_EN
    .irq      (irq),
`endif
    .dbgState (dbgState)
  );

`ifndef UART_TX_IRQ_EN
  assign irq = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // tx sampled mid-cycle while recording is enabled
  initial begin
    forever begin
      @(negedge clk);
      if (recOn) txRec.push_back(tx);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    sel = 1'b1; we = 1'b1; addr = a; wdata = d;
    @(posedge clk);
    #1;
    sel = 1'b0; we = 1'b0; wdata = '0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    sel = 1'b1; we = 1'b0; addr = a;
    #1;
    d = rdata;
    sel = 1'b0;
  endtask

  task automatic rec_start();
    txRec.delete();
    recOn = 1'b1;
  endtask

  // Expected line level k cycles after the edge that triggered the first
  // frame, for the bytes in expQ sent contiguously at divisor d.
  function automatic logic exp_tx(input int d, input int k);
    int idx, f, b;
    if (k == 0) return 1'b1;
    idx = k - 1;
    f = idx / (10 * d);
    if (f >= expQ.size()) return 1'b1;
    b = (idx % (10 * d)) / d;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return expQ[f][b-1];
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0; sel = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    totalCnt++;
    if (tx !== 1'b1) $display("FAIL reset_tx: got %b expected 1", tx);
    else passCnt++;
    rd(4'h4, rv);
    totalCnt++;
    if (rv !== 32'h4) $display("FAIL reset_status: got %0h expected 4", rv);
    else passCnt++;
    rd(4'h8, rv);
    totalCnt++;
    if (rv !== 32'd868) $display("FAIL reset_divisor: got %0d expected 868", rv);
    else passCnt++;
    rd(4'hC, rv);
    totalCnt++;
    if (rv !== 32'h1) $display("FAIL reset_ctrl: got %0h expected 1", rv);
    else passCnt++;
    rd(4'h0, rv);
    totalCnt++;
    if (rv !== 32'h0) $display("FAIL reset_txdata_read: got %0h expected 0", rv);
    else passCnt++;
    addr = 4'h8;
    #1;
    totalCnt++;
    if (rdata !== 32'h0) $display("FAIL rdata_unselected: got %0h expected 0", rdata);
    else passCnt++;
    totalCnt++;
    if (irq !== 1'b0) $display("FAIL reset_irq: got %b expected 0", irq);
    else passCnt++;
  endtask

  task automatic test_single_frame();
    wr(4'h8, 32'd4);
    expQ.delete();
    expQ.push_back(8'h55);
    wr(4'h0, 32'h55);
    rec_start();
    tick(40);
    rd(4'h4, rv);
    totalCnt++;
    if (rv[0] !== 1'b1) $display("FAIL frame_busy_last: got %b expected 1", rv[0]);
    else passCnt++;
    tick(1);
    rd(4'h4, rv);
    totalCnt++;
    if (rv !== 32'h4) $display("FAIL frame_status_after: got %0h expected 4", rv);
    else passCnt++;
    tick(3);
    recOn = 1'b0;
    totalCnt++;
    if (txRec.size() !== 44) $display("FAIL frame_len: got %0d expected 44", txRec.size());
    else passCnt++;
    for (int k = 0; k < txRec.size(); k++) begin
      totalCnt++;
      if (txRec[k] !== exp_tx(4, k))
        $display("FAIL frame_tx[%0d]: got %b expected %b", k, txRec[k], exp_tx(4, k));
      else passCnt++;
    end
  endtask

  task automatic test_back_to_back();
    wr(4'h8, 32'd2);
    expQ.delete();
    expQ.push_back(8'hA5);
    expQ.push_back(8'h3C);
    wr(4'h0, 32'hA5);
    rec_start();
    wr(4'h0, 32'h3C);
    tick(40);
    rd(4'h4, rv);
    totalCnt++;
    if (rv !== 32'h4) $display("FAIL b2b_status_after: got %0h expected 4", rv);
    else passCnt++;
    tick(2);
    recOn = 1'b0;
    totalCnt++;
    if (txRec.size() !== 43) $display("FAIL b2b_len: got %0d expected 43", txRec.size());
    else passCnt++;
    for (int k = 0; k < txRec.size(); k++) begin
      totalCnt++;
      if (txRec[k] !== exp_tx(2, k))
        $display("FAIL b2b_tx[%0d]: got %b expected %b", k, txRec[k], exp_tx(2, k));
      else passCnt++;
    end
  endtask

  task automatic test_overflow();
    wr(4'hC, 32'h0);
    wr(4'h8, 32'd2);
    expQ.delete();
    for (int i = 0; i < 9; i++) begin
      wr(4'h0, 32'h10 + i);
      if (i < 8) expQ.push_back(8'(8'h10 + i));
    end
    rd(4'h4, rv);
    totalCnt++;
    if (rv !== 32'h8A) $display("FAIL ovf_status_full: got %0h expected 8a", rv);
    else passCnt++;
    wr(4'h4, 32'h8);
    rd(4'h4, rv);
    totalCnt++;
    if (rv !== 32'h82) $display("FAIL ovf_status_cleared: got %0h expected 82", rv);
    else passCnt++;
    wr(4'hC, 32'h1);
    rec_start();
    tick(162);
    rd(4'h4, rv);
    totalCnt++;
    if (rv !== 32'h4) $display("FAIL ovf_status_drained: got %0h expected 4", rv);
    else passCnt++;
    recOn = 1'b0;
    totalCnt++;
    if (txRec.size() !== 162) $display("FAIL ovf_len: got %0d expected 162", txRec.size());
    else passCnt++;
    for (int k = 0; k < txRec.size(); k++) begin
      totalCnt++;
      if (txRec[k] !== exp_tx(2, k))
        $display("FAIL ovf_tx[%0d]: got %b expected %b", k, txRec[k], exp_tx(2, k));
      else passCnt++;
    end
  endtask

  task automatic test_full_push_pop();
    wr(4'hC, 32'h0);
    expQ.delete();
    for (int i = 0; i < 8; i++) begin
      wr(4'h0, 32'h20 + i);
      expQ.push_back(8'(8'h20 + i));
    end
    expQ.push_back(8'h28);
    expQ.push_back(8'hC3);
    rd(4'h4, rv);
    totalCnt++;
    if (rv !== 32'h82) $display("FAIL full_status_before: got %0h expected 82", rv);
    else passCnt++;
    wr(4'hC, 32'h1);
    rec_start();
    wr(4'h0, 32'h28);
    rd(4'h4, rv);
    totalCnt++;
    if (rv !== 32'h83) $display("FAIL full_idle_pushpop: got %0h expected 83", rv);
    else passCnt++;
    tick(19);
    rd(4'h4, rv);
    totalCnt++;
    if (rv !== 32'h83) $display("FAIL full_before_stop_end: got %0h expected 83", rv);
    else passCnt++;
    wr(4'h0, 32'hC3);
    rd(4'h4, rv);
    totalCnt++;
    if (rv !== 32'h83) $display("FAIL full_stop_pushpop: got %0h expected 83", rv);
    else passCnt++;
    tick(180);
    rd(4'h4, rv);
    totalCnt++;
    if (rv !== 32'h4) $display("FAIL full_status_drained: got %0h expected 4", rv);
    else passCnt++;
    recOn = 1'b0;
    totalCnt++;
    if (txRec.size() !== 201) $display("FAIL full_len: got %0d expected 201", txRec.size());
    else passCnt++;
    for (int k = 0; k < txRec.size(); k++) begin
      totalCnt++;
      if (txRec[k] !== exp_tx(2, k))
        $display("FAIL full_tx[%0d]: got %b expected %b", k, txRec[k], exp_tx(2, k));
      else passCnt++;
    end
  endtask

  task automatic test_divisor_ctrl();
    logic [31:0] ctrlExp;
    wr(4'h8, 32'h0);
    rd(4'h8, rv);
    totalCnt++;
    if (rv !== 32'h1) $display("FAIL div_zero: got %0h expected 1", rv);
    else passCnt++;
    wr(4'hA, 32'hABCD_FFFF);
    rd(4'h9, rv);
    totalCnt++;
    if (rv !== 32'hFFFF) $display("FAIL div_max_alias: got %0h expected ffff", rv);
    else passCnt++;
`ifdef UART_TX_IRQ_EN
    ctrlExp = 32'h3;
`else
    ctrlExp = 32'h1;
`endif
    wr(4'hC, 32'hFFFF_FFFF);
    rd(4'hC, rv);
    totalCnt++;
    if (rv !== ctrlExp) $display("FAIL ctrl_all_ones: got %0h expected %0h", rv, ctrlExp);
    else passCnt++;
    wr(4'hC, 32'h1);
    wr(4'h8, 32'd2);
  endtask

  task automatic test_irq();
`ifdef UART_TX_IRQ_EN
    wr(4'hC, 32'h3);
    totalCnt++;
    if (irq !== 1'b0) $display("FAIL irq_before_rise: got %b expected 0", irq);
    else passCnt++;
    tick(1);
    totalCnt++;
    if (irq !== 1'b1) $display("FAIL irq_idle_rise: got %b expected 1", irq);
    else passCnt++;
    wr(4'h0, 32'h5A);
    totalCnt++;
    if (irq !== 1'b1) $display("FAIL irq_push_edge: got %b expected 1", irq);
    else passCnt++;
    tick(1);
    totalCnt++;
    if (irq !== 1'b0) $display("FAIL irq_push_fall: got %b expected 0", irq);
    else passCnt++;
    tick(20);
    totalCnt++;
    if (irq !== 1'b0 || dbgState !== 2'd0)
      $display("FAIL irq_idle_entry: got irq=%b state=%0d expected irq=0 state=0", irq, dbgState);
    else passCnt++;
    tick(1);
    totalCnt++;
    if (irq !== 1'b1) $display("FAIL irq_after_frame: got %b expected 1", irq);
    else passCnt++;
    wr(4'hC, 32'h1);
    tick(1);
    totalCnt++;
    if (irq !== 1'b0) $display("FAIL irq_en_cleared: got %b expected 0", irq);
    else passCnt++;
`endif
  endtask

  task automatic test_reset_mid_frame();
    wr(4'h8, 32'd4);
    wr(4'hC, 32'h1);
    wr(4'h0, 32'h00);
    wr(4'h0, 32'h00);
    tick(10);
    totalCnt++;
    if (tx !== 1'b0) $display("FAIL midrst_in_data: got %b expected 0", tx);
    else passCnt++;
    reset = 1'b0;
    tick(1);
    totalCnt++;
    if (tx !== 1'b1) $display("FAIL midrst_tx: got %b expected 1", tx);
    else passCnt++;
    totalCnt++;
    if (irq !== 1'b0) $display("FAIL midrst_irq: got %b expected 0", irq);
    else passCnt++;
    rd(4'h4, rv);
    totalCnt++;
    if (rv !== 32'h4) $display("FAIL midrst_status: got %0h expected 4", rv);
    else passCnt++;
    reset = 1'b1;
    rd(4'h8, rv);
    totalCnt++;
    if (rv !== 32'd868) $display("FAIL midrst_divisor: got %0d expected 868", rv);
    else passCnt++;
    tick(50);
    totalCnt++;
    if (tx !== 1'b1 || dbgState !== 2'd0)
      $display("FAIL midrst_discarded: got tx=%b state=%0d expected tx=1 state=0", tx, dbgState);
    else passCnt++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_overflow();
    test_full_push_pop();
    test_divisor_ctrl();
    test_irq();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
